// File: rtl/alu_ctrl_decode.sv
// Registered MIPS decode stage: instr -> ALU op and operand selects, one cycle after accept.
// Valid/ready on both sides; main + skid registers give full throughput, in_ready is registered.
module alu_ctrl_decode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic [1:0]       a_sel,
  output logic             b_sel,
  output logic [31:0]      imm_ext,
  output logic [4:0]       dest,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDU = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUBU = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_LUI  = 4'b1101;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm_ext;
    logic [4:0]  dest;
    logic        reg_write;
    logic        illegal;
  } dec_t;

  logic [5:0]  w_opc;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic        w_unused_rs;
  logic        w_acc;
  logic        w_drain;
  dec_t        w_dec;

  dec_t             r_main;
  dec_t             r_skid;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic             r_in_rdy;
  logic [CNT_W-1:0] r_cnt;

  assign w_opc       = instr[31:26];
  assign w_funct     = instr[5:0];
  assign w_rt        = instr[20:16];
  assign w_rd        = instr[15:11];
  assign w_sext      = {{16{instr[15]}}, instr[15:0]};
  assign w_zext      = {16'h0000, instr[15:0]};
  assign w_unused_rs = ^instr[25:21];

  // Default is the illegal bundle; legal encodings overwrite it.
  always_comb begin
    w_dec         = '0;
    w_dec.alu_op  = OP_ADDU;
    w_dec.illegal = 1'b1;
    case (w_opc)
      6'b000000: begin
        w_dec.illegal   = 1'b0;
        w_dec.dest      = w_rd;
        w_dec.reg_write = (w_rd != 5'd0);
        case (w_funct)
          6'b100000: w_dec.alu_op = OP_ADD;
          6'b100001: w_dec.alu_op = OP_ADDU;
          6'b100010: w_dec.alu_op = OP_SUB;
          6'b100011: w_dec.alu_op = OP_SUBU;
          6'b100100: w_dec.alu_op = OP_AND;
          6'b100101: w_dec.alu_op = OP_OR;
          6'b100110: w_dec.alu_op = OP_XOR;
          6'b100111: w_dec.alu_op = OP_NOR;
          6'b101010: w_dec.alu_op = OP_SLT;
          6'b101011: w_dec.alu_op = OP_SLTU;
          6'b000000: begin w_dec.alu_op = OP_SLL; w_dec.a_sel = 2'd1; end
          6'b000010: begin w_dec.alu_op = OP_SRL; w_dec.a_sel = 2'd1; end
          6'b000011: begin w_dec.alu_op = OP_SRA; w_dec.a_sel = 2'd1; end
          6'b000100: begin w_dec.alu_op = OP_SLL; w_dec.a_sel = 2'd2; end
          6'b000110: begin w_dec.alu_op = OP_SRL; w_dec.a_sel = 2'd2; end
          6'b000111: begin w_dec.alu_op = OP_SRA; w_dec.a_sel = 2'd2; end
          default: begin
            w_dec.illegal   = 1'b1;
            w_dec.alu_op    = OP_ADDU;
            w_dec.dest      = 5'd0;
            w_dec.reg_write = 1'b0;
          end
        endcase
      end
      6'b000100, 6'b000101: begin
        w_dec.illegal = 1'b0;
        w_dec.alu_op  = OP_SUBU;
        w_dec.imm_ext = w_sext;
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        w_dec.illegal   = 1'b0;
        w_dec.b_sel     = 1'b1;
        w_dec.dest      = w_rt;
        w_dec.reg_write = (w_rt != 5'd0);
        // 0011xx are the logical ops and LUI, which take the zero-extended immediate.
        w_dec.imm_ext   = w_opc[2] ? w_zext : w_sext;
        case (w_opc[2:0])
          3'b000:  w_dec.alu_op = OP_ADD;
          3'b001:  w_dec.alu_op = OP_ADDU;
          3'b010:  w_dec.alu_op = OP_SLT;
          3'b011:  w_dec.alu_op = OP_SLTU;
          3'b100:  w_dec.alu_op = OP_AND;
          3'b101:  w_dec.alu_op = OP_OR;
          3'b110:  w_dec.alu_op = OP_XOR;
          default: w_dec.alu_op = OP_LUI;
        endcase
      end
      default: ;
    endcase
  end

  assign w_acc   = in_valid & r_in_rdy;
  assign w_drain = r_main_vld & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_rdy   <= 1'b1;
      r_cnt      <= '0;
    end else begin
      if (w_acc && w_dec.illegal && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_drain) begin
        if (r_skid_vld) begin
          r_main     <= r_skid;
          r_skid_vld <= 1'b0;
          r_in_rdy   <= 1'b1;
        end else if (w_acc) begin
          r_main <= w_dec;
        end else begin
          r_main_vld <= 1'b0;
        end
      end else if (w_acc) begin
        if (r_main_vld) begin
          r_skid     <= w_dec;
          r_skid_vld <= 1'b1;
          r_in_rdy   <= 1'b0;
        end else begin
          r_main     <= w_dec;
          r_main_vld <= 1'b1;
        end
      end
    end
  end

  assign in_ready    = r_in_rdy;
  assign out_valid   = r_main_vld;
  assign alu_op      = r_main.alu_op;
  assign a_sel       = r_main.a_sel;
  assign b_sel       = r_main.b_sel;
  assign imm_ext     = r_main.imm_ext;
  assign dest        = r_main.dest;
  assign reg_write   = r_main.reg_write;
  assign illegal     = r_main.illegal;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Scoreboard bench for alu_ctrl_decode: directed MIPS words with hand-decoded expectations.
module tb_alu_ctrl_decode;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, imm_ext;
  logic [3:0]  alu_op;
  logic [1:0]  a_sel;
  logic        b_sel, reg_write, illegal;
  logic [4:0]  dest;
  logic [15:0] illegal_cnt;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_instr, s_imm_ext;
  logic [3:0]  s_alu_op;
  logic [1:0]  s_a_sel;
  logic        s_b_sel, s_reg_write, s_illegal;
  logic [4:0]  s_dest;
  logic [1:0]  s_illegal_cnt;

  alu_ctrl_decode #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .a_sel(a_sel),
    .b_sel(b_sel), .imm_ext(imm_ext), .dest(dest), .reg_write(reg_write),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  alu_ctrl_decode #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .instr(s_instr),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .alu_op(s_alu_op), .a_sel(s_a_sel),
    .b_sel(s_b_sel), .imm_ext(s_imm_ext), .dest(s_dest), .reg_write(s_reg_write),
    .illegal(s_illegal), .illegal_cnt(s_illegal_cnt)
  );

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  alu;
    logic [1:0]  a;
    logic        b;
    logic [31:0] imm;
    bit          chk_imm;
    logic [4:0]  d;
    logic        rw;
    logic        ill;
  } exp_t;

  exp_t pend[$];
  exp_t sb[$];
  bit   rdy_log[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;

  function automatic exp_t mk(input logic [31:0] ins, input logic [3:0] alu, input logic [1:0] a,
                              input logic b, input logic [31:0] imm, input bit ci,
                              input logic [4:0] d, input logic rw, input logic ill);
    exp_t e;
    e.ins = ins; e.alu = alu; e.a = a; e.b = b; e.imm = imm; e.chk_imm = ci;
    e.d = d; e.rw = rw; e.ill = ill;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever valid & ready hold at the negedge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=alu_op %h required=no output", alu_op);
      end else begin
        e = sb.pop_front();
        check($sformatf("bundle_%h", e.ins),
              {alu_op, a_sel, b_sel, dest, reg_write, illegal, (e.chk_imm ? imm_ext : 32'h0)},
              {e.alu, e.a, e.b, e.d, e.rw, e.ill, (e.chk_imm ? e.imm : 32'h0)});
      end
    end
  end

  task automatic drive(input int ncyc);
    for (int c = 0; c < ncyc && pend.size() > 0; c++) begin
      in_valid = 1'b1;
      instr    = pend[0].ins;
      @(negedge clk);
      rdy_log.push_back(in_ready);
      if (in_ready) sb.push_back(pend.pop_front());
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && sb.size() > 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_instr = 32'hFC000000; s_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_illegal_cnt", illegal_cnt, 0);
    check("rst_payload", {alu_op, a_sel, b_sel, imm_ext, dest, reg_write, illegal}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add $8,$9,$10 with one-cycle latency
    pend.push_back(mk(32'h012A4020, 4'b0000, 2'd0, 1'b0, 32'h0, 0, 5'd8, 1'b1, 1'b0));
    drive(1);
    check("latency_out_valid", out_valid, 1);
    wait_drain();

    // three illegal opcodes
    repeat (3) pend.push_back(mk(32'hFC000000, 4'b0001, 2'd0, 1'b0, 32'h0, 0, 5'd0, 1'b0, 1'b1));
    drive(20);
    wait_drain();
    check("illegal_cnt_3", illegal_cnt, 3);

    // immediates, shifts, nop, branch, undefined funct, LUI, rt=0, SLTU
    pend.push_back(mk(32'h24A4FFFF, 4'b0001, 2'd0, 1'b1, 32'hFFFFFFFF, 1, 5'd4, 1'b1, 1'b0));
    pend.push_back(mk(32'h34A4FFFF, 4'b0101, 2'd0, 1'b1, 32'h0000FFFF, 1, 5'd4, 1'b1, 1'b0));
    pend.push_back(mk(32'h000219C3, 4'b1100, 2'd1, 1'b0, 32'h0, 0, 5'd3, 1'b1, 1'b0));
    pend.push_back(mk(32'h00221807, 4'b1100, 2'd2, 1'b0, 32'h0, 0, 5'd3, 1'b1, 1'b0));
    pend.push_back(mk(32'h00000000, 4'b1010, 2'd1, 1'b0, 32'h0, 0, 5'd0, 1'b0, 1'b0));
    pend.push_back(mk(32'h11090003, 4'b0011, 2'd0, 1'b0, 32'h0, 0, 5'd0, 1'b0, 1'b0));
    pend.push_back(mk(32'h0000003F, 4'b0001, 2'd0, 1'b0, 32'h0, 0, 5'd0, 1'b0, 1'b1));
    pend.push_back(mk(32'h3C071234, 4'b1101, 2'd0, 1'b1, 32'h00001234, 1, 5'd7, 1'b1, 1'b0));
    pend.push_back(mk(32'h2000FFFF, 4'b0000, 2'd0, 1'b1, 32'hFFFFFFFF, 1, 5'd0, 1'b0, 1'b0));
    pend.push_back(mk(32'h0043082B, 4'b1001, 2'd0, 1'b0, 32'h0, 0, 5'd1, 1'b1, 1'b0));
    drive(40);
    wait_drain();
    check("illegal_cnt_4", illegal_cnt, 4);

    // backpressure: four back-to-back with the sink stalled
    out_ready = 1'b0;
    rdy_log.delete();
    pend.push_back(mk(32'h012A4020, 4'b0000, 2'd0, 1'b0, 32'h0, 0, 5'd8, 1'b1, 1'b0));
    pend.push_back(mk(32'h24A4FFFF, 4'b0001, 2'd0, 1'b1, 32'hFFFFFFFF, 1, 5'd4, 1'b1, 1'b0));
    pend.push_back(mk(32'h00221807, 4'b1100, 2'd2, 1'b0, 32'h0, 0, 5'd3, 1'b1, 1'b0));
    pend.push_back(mk(32'h3C071234, 4'b1101, 2'd0, 1'b1, 32'h00001234, 1, 5'd7, 1'b1, 1'b0));
    drive(4);
    check("bp_in_ready_trace", {rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3]}, 4'b1100);
    check("bp_accepted", sb.size(), 2);
    check("bp_out_valid_held", out_valid, 1);
    n0 = n_out;
    out_ready = 1'b1;
    drive(20);
    wait_drain();
    check("bp_out_count", n_out - n0, 4);

    // reset with two bundles buffered
    out_ready = 1'b0;
    repeat (2) pend.push_back(mk(32'hFC000000, 4'b0001, 2'd0, 1'b0, 32'h0, 0, 5'd0, 1'b0, 1'b1));
    drive(2);
    check("pre_rst_in_ready", in_ready, 0);
    check("pre_rst_cnt", illegal_cnt, 6);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_cnt", illegal_cnt, 0);
    sb.delete();
    pend.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    out_ready = 1'b1;

    // CNT_W = 2 saturation
    check("sat_cnt_start", s_illegal_cnt, 0);
    for (int k = 1; k <= 4; k++) begin
      s_in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("sat_cnt_%0d", k), s_illegal_cnt, (k < 3) ? k : 3);
    end
    s_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sat_cnt_hold", s_illegal_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
